// File: rtl/rgb_pwm_pkg.sv
// Shared types, register map and address decode for the rgb_pwm block.
package rgb_pwm_pkg;

    typedef logic [7:0] duty_t;

    localparam int NUM_CH = 3;

    localparam logic [3:0] DUTY_R_OFS = 4'h0;
    localparam logic [3:0] DUTY_G_OFS = 4'h4;
    localparam logic [3:0] DUTY_B_OFS = 4'h8;
    localparam logic [3:0] CTRL_OFS   = 4'hC;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } reg_sel_t;

    // Word-aligned hit inside the 16-byte window starting at base.
    function automatic reg_sel_t decode(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_t   sel;
        logic [31:0] ofs;
        ofs     = addr - base;
        sel.hit = (ofs[31:4] == '0) && (ofs[1:0] == 2'b00);
        sel.idx = ofs[3:2];
        return sel;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: shadow duty register and registered compare output.
// With RGB_PWM_FADE_EN the shadow walks one step per period toward staging.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  enable,
    input  logic  enable_next,
    input  logic  period_end,
    input  duty_t pwm_cnt,
    input  duty_t staging,
    input  duty_t staging_next,
    output logic  pwm_out
);

    duty_t shadow_q, shadow_d;
    logic  out_q, out_d;

    always_comb begin
        shadow_d = shadow_q;
        // While idle the shadow follows the incoming value so a re-enable starts clean.
        if (!enable) begin
            shadow_d = staging_next;
        end else if (period_end) begin
`ifdef RGB_PWM_FADE_EN
            if (shadow_q < staging)      shadow_d = shadow_q + 8'd1;
            else if (shadow_q > staging) shadow_d = shadow_q - 8'd1;
`else
            shadow_d = staging;
`endif
        end
        out_d = enable_next && (pwm_cnt < shadow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign pwm_out = out_q;

endmodule

// File: rtl/rgb_pwm.sv
// Memory-mapped three-channel PWM LED driver with period-aligned duty updates.
// Define RGB_PWM_FADE_EN for one-step-per-period hardware fading.
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFE0,
    parameter int          PRESCALE  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    duty_t [NUM_CH-1:0] staging_q, staging_d;
    logic               enable_q, enable_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    duty_t              pwm_cnt_q, pwm_cnt_d;
    logic [31:0]        read_data_q, read_data_d;
    reg_sel_t           wsel, rsel;
    logic               tick, period_end;
    logic [NUM_CH-1:0]  ch_out;

    // Every store width lands in byte 0, so funct3 and the upper data bytes are don't-care.
    logic unused_bits;
    assign unused_bits = ^{funct3, write_data[31:8]};

    always_comb begin
        wsel      = decode(write_address, BASE_ADDR);
        rsel      = decode(read_address, BASE_ADDR);
        staging_d = staging_q;
        enable_d  = enable_q;
        if (write_mem && wsel.hit) begin
            case ({wsel.idx, 2'b00})
                DUTY_R_OFS: staging_d[0] = write_data[7:0];
                DUTY_G_OFS: staging_d[1] = write_data[7:0];
                DUTY_B_OFS: staging_d[2] = write_data[7:0];
                CTRL_OFS:   enable_d     = write_data[0];
                default:    ;
            endcase
        end

        tick       = (pre_cnt_q == PRE_LAST);
        period_end = enable_q && tick && (pwm_cnt_q == 8'hFF);

        // Counters only run once enable has been stable for a cycle, so a fresh enable starts at 0.
        pre_cnt_d = '0;
        pwm_cnt_d = '0;
        if (enable_q && enable_d) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
            pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        end

        read_data_d = '0;
        if (rsel.hit) begin
            case ({rsel.idx, 2'b00})
                DUTY_R_OFS: read_data_d = {24'b0, staging_q[0]};
                DUTY_G_OFS: read_data_d = {24'b0, staging_q[1]};
                DUTY_B_OFS: read_data_d = {24'b0, staging_q[2]};
                CTRL_OFS:   read_data_d = {31'b0, enable_q};
                default:    read_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q   <= '0;
            enable_q    <= 1'b0;
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            read_data_q <= '0;
        end else begin
            staging_q   <= staging_d;
            enable_q    <= enable_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            read_data_q <= read_data_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .enable       (enable_q),
            .enable_next  (enable_d),
            .period_end   (period_end),
            .pwm_cnt      (pwm_cnt_q),
            .staging      (staging_q[c]),
            .staging_next (staging_d[c]),
            .pwm_out      (ch_out[c])
        );
    end

    assign read_data = read_data_q;
    assign red       = ch_out[0];
    assign green     = ch_out[1];
    assign blue      = ch_out[2];

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm: directed scenarios plus random traffic against a period-position model.
module tb_rgb_pwm;

    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
    localparam int          P    = 2;
    localparam int          PLEN = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        write_mem = 1'b0;
    logic [2:0]  funct3 = 3'd2;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        red, green, blue;

    rgb_pwm #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_mem     (write_mem),
        .funct3        (funct3),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the PWM period instead of separate counters.
    int          m_pos = 0;
    bit          m_en = 0;
    int          m_stg[3] = '{0, 0, 0};
    int          m_shd[3] = '{0, 0, 0};
    bit [2:0]    m_out = '0;
    logic [31:0] m_rd = '0;
    bit          last_pe = 0;
    bit          win_on = 0;
    int          win_cnt[3] = '{0, 0, 0};
    int          win_exp[3] = '{0, 0, 0};
    int          last_win[3] = '{0, 0, 0};

`ifdef RGB_PWM_FADE_EN
    int fade_exp[4] = '{2, 4, 6, 6};
`else
    int fade_exp[4] = '{6, 6, 6, 6};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int reg_idx(input logic [31:0] a);
        logic [31:0] d;
        if (a < BASE) return -1;
        d = a - BASE;
        if (d > 32'd15 || d[1:0] != 2'b00) return -1;
        return int'(d[3:2]);
    endfunction

    // Advance one clock: predict from current inputs, cross a posedge, then compare at the negedge.
    task automatic step();
        bit       en_n;
        int       stg_n[3];
        int       shd_n[3];
        int       pos_n, wi, ri, cnt;
        bit       pe;
        bit [2:0] out_n;
        logic [31:0] rd_n;
        en_n = m_en; stg_n = m_stg; shd_n = m_shd;
        pos_n = 0; pe = 0; out_n = '0; rd_n = '0;
        if (rst_n) begin
            wi = write_mem ? reg_idx(write_address) : -1;
            if (wi == 3) en_n = write_data[0];
            else if (wi >= 0) stg_n[wi] = int'(write_data[7:0]);
            cnt = m_pos / P;
            pe  = m_en && (m_pos == PLEN - 1);
            for (int c = 0; c < 3; c++) begin
                out_n[c] = en_n && (cnt < m_shd[c]);
                if (!m_en) shd_n[c] = stg_n[c];
                else if (pe) begin
`ifdef RGB_PWM_FADE_EN
                    if (m_shd[c] < m_stg[c]) shd_n[c] = m_shd[c] + 1;
                    else if (m_shd[c] > m_stg[c]) shd_n[c] = m_shd[c] - 1;
`else
                    shd_n[c] = m_stg[c];
`endif
                end
            end
            ri = reg_idx(read_address);
            if (ri == 3) rd_n = {31'b0, m_en};
            else if (ri >= 0) rd_n = 32'(m_stg[ri]);
            pos_n = (m_en && en_n) ? (m_pos + 1) % PLEN : 0;
            if (m_en && m_pos == 0) begin
                win_on = 1;
                for (int c = 0; c < 3; c++) begin
                    win_cnt[c] = 0;
                    win_exp[c] = P * m_shd[c];
                end
            end
            if (!en_n) win_on = 0;
        end else begin
            en_n = 0; stg_n = '{0, 0, 0}; shd_n = '{0, 0, 0}; win_on = 0;
        end
        @(negedge clk);
        m_en = en_n; m_stg = stg_n; m_shd = shd_n; m_pos = pos_n;
        m_out = out_n; m_rd = rd_n; last_pe = pe;
        chk("red", red, m_out[0]);
        chk("green", green, m_out[1]);
        chk("blue", blue, m_out[2]);
        chk("rdata", read_data, m_rd);
        if (win_on) begin
            win_cnt[0] += int'(red);
            win_cnt[1] += int'(green);
            win_cnt[2] += int'(blue);
            if (pe) begin
                chk("win_r", win_cnt[0], win_exp[0]);
                chk("win_g", win_cnt[1], win_exp[1]);
                chk("win_b", win_cnt[2], win_exp[2]);
                last_win = win_cnt;
                win_on = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        write_mem = 1'b1; write_address = addr; write_data = data;
        funct3 = 3'($urandom_range(0, 2));
        step();
        write_mem = 1'b0;
    endtask

    task automatic run_to_pe();
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_pe && n < 2 * PLEN);
        if (!last_pe) chk("pe_timeout", 32'(n), 32'(2 * PLEN + 1));
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 11))
            0, 1, 2: return BASE;
            3, 4:    return BASE + 32'd4;
            5, 6:    return BASE + 32'd8;
            7:       return BASE + 32'd12;
            8:       return BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 3));
            9:       return BASE + 32'd16;
            10:      return BASE - 32'd4;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        #1 rst_n = 1'b0;
        idle(3);
        chk("rst_rgb", {29'b0, red, green, blue}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            read_address = BASE + 32'(4 * k);
            step();
            chk("rst_rd", read_data, 32'd0);
        end

        // Basic duties: R=64, G=0, B=255.
        wr(BASE, 32'hABCD_EF40);
        wr(BASE + 32'd4, 32'h0000_0100);
        wr(BASE + 32'd8, 32'h0000_00FF);
        wr(BASE + 32'd1, 32'h0000_0011);
        wr(BASE + 32'd12, 32'h0000_0001);
        read_address = BASE;
        for (int i = 0; i < 3; i++) run_to_pe();
        chk("red_128", last_win[0], 32'd128);
        chk("green_0", last_win[1], 32'd0);
        chk("blue_510", last_win[2], 32'd510);
        chk("rd_r", read_data, 32'd64);

        // Write landing exactly on the period end.
        n = 0;
        while (!(m_en && m_pos == PLEN - 1) && n < 2 * PLEN) begin
            step();
            n++;
        end
        wr(BASE, 32'd200);
        chk("simul_pe", {31'b0, last_pe}, 32'd1);
        run_to_pe();
        chk("simul_old", last_win[0], 32'd128);
        run_to_pe();
        chk("simul_new", last_win[0], 32'd400);

        // Green 0 -> 3: fade steps or one-shot load.
        idle(37);
        wr(BASE + 32'd4, 32'd3);
        run_to_pe();
        for (int i = 0; i < 4; i++) begin
            run_to_pe();
            chk($sformatf("fade_%0d", i), last_win[1], 32'(fade_exp[i]));
        end

        // Disable mid-pulse, then re-enable.
        idle(20);
        chk("pre_dis_red", {31'b0, red}, 32'd1);
        wr(BASE + 32'd12, 32'd0);
        chk("dis_rgb", {29'b0, red, green, blue}, 32'd0);
        read_address = BASE + 32'd12;
        idle(50);
        chk("dis_ctrl", read_data, 32'd0);
        wr(BASE + 32'd12, 32'd1);
        run_to_pe();
        chk("reen_red", last_win[0], 32'd400);

        // Reset in the middle of a period.
        idle(300);
        rst_n = 1'b0;
        step();
        chk("mid_rst_rgb", {29'b0, red, green, blue}, 32'd0);
        rst_n = 1'b1;
        read_address = BASE;
        idle(600);
        chk("post_rst_rgb", {29'b0, red, green, blue}, 32'd0);
        chk("post_rst_rd", read_data, 32'd0);

        // Random traffic.
        wr(BASE + 32'd12, 32'd1);
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                write_mem = 1'b1;
                write_address = rand_addr();
                write_data = $urandom;
                if (write_address == BASE + 32'd12) write_data[0] = ($urandom_range(0, 3) != 0);
                funct3 = 3'($urandom_range(0, 2));
            end else begin
                write_mem = 1'b0;
            end
            read_address = rand_addr();
            if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        write_mem = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
